// File: rtl/fifo_merge_pkg.sv
// Shared definitions for the round-robin FIFO merge block: the FSM state type
// and the default parameter values used by the top level and its sub-module.
package fifo_merge_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage : fifo_merge_pkg

// File: rtl/fifo_rr_merge_rr_pick.sv
// Rotate-priority encoder: returns the first asserted request found by
// searching upward from ptr, wrapping from NUM_CH-1 back to 0.
module rr_pick
    import fifo_merge_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [IDX_W-1:0] cand;

    // Walk the channels starting at ptr; the first request seen wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise an untaken branch infers a latch.
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
            cand = (cand == IDX_W'(NUM_CH - 1)) ? '0 : cand + IDX_W'(1);
        end
    end

endmodule : rr_pick

// File: rtl/fifo_rr_merge.sv
// Merges NUM_CH source FIFOs into one destination FIFO. An idle cycle picks
// the next eligible channel round-robin; the burst then moves up to MAX_BURST
// words straight from the source head to the destination, with no data
// register in between.
module fifo_rr_merge
    import fifo_merge_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_CH-1:0]          SRC_EMPTY_N,
    input  logic [NUM_CH*WIDTH-1:0]    SRC_D_OUT,
    output logic [NUM_CH-1:0]          SRC_DEQ,
    input  logic [NUM_CH-1:0]          CH_EN,
    input  logic                       DST_FULL_N,
    output logic                       DST_ENQ,
    output logic [WIDTH-1:0]           DST_D_IN,
    output logic [$clog2(NUM_CH)-1:0]  DST_CH,
    output logic                       BUSY
);

    localparam int CW = $clog2(NUM_CH);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_e          state_q,    state_d;
    logic [CW-1:0]   grant_q,    grant_d;
    logic [CW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_CH-1:0] elig;
    logic [CW-1:0]     pick_idx;
    logic              pick_any;
    logic              grant_live;
    logic              xfer;

    assign elig = SRC_EMPTY_N & CH_EN;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CW)
    ) u_rr_pick (
        .req (elig),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state and handshake outputs; reset is synchronous, so it simply
    // overrides both the outputs and the next-state values at the end.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_live = 1'b0;
        xfer       = 1'b0;
        SRC_DEQ    = '0;
        DST_ENQ    = 1'b0;
        DST_D_IN   = '0;
        DST_CH     = '0;
        BUSY       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                BUSY       = 1'b1;
                DST_CH     = grant_q;
                grant_live = SRC_EMPTY_N[grant_q] & CH_EN[grant_q];
                xfer       = grant_live & DST_FULL_N;
                DST_ENQ          = xfer;
                SRC_DEQ[grant_q] = xfer;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (grant_q == CW'(i)) begin
                        DST_D_IN = SRC_D_OUT[i*WIDTH +: WIDTH];
                    end
                end
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                // A full destination alone never ends the burst; running out of
                // beats, an empty source or a disabled channel does, exactly once.
                if ((xfer && (beat_cnt_q == BW'(MAX_BURST - 1))) || !grant_live) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (RST) begin
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = '0;
            beat_cnt_d = '0;
            SRC_DEQ    = '0;
            DST_ENQ    = 1'b0;
            DST_D_IN   = '0;
            DST_CH     = '0;
            BUSY       = 1'b0;
        end
    end

    // State register; reset values arrive through the _d signals.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples its pre-edge inputs regardless of statement order.
        state_q    <= state_d;
        grant_q    <= grant_d;
        rr_ptr_q   <= rr_ptr_d;
        beat_cnt_q <= beat_cnt_d;
    end

endmodule : fifo_rr_merge
